crtc_timing: RTL and testbench

CRTC_TIMING -- requirements
Module: crtc_timing

---
 rtl/common_pkg.sv | 56 +++++
 rtl/crtc_reg_file.sv | 39 +++
 rtl/crtc_timing.sv | 150 +++++++++++++++
 tb/tb_crtc_timing.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared CRTC definitions: register indices, bus widths and the decoded
// register set handed from the register file to the timing core.
package common_pkg;

  localparam int SYS_CLOCK_MHZ   = 50;
  localparam int DATA_WIDTH      = 8;
  localparam int CRTC_ADDR_WIDTH = 5;
  localparam int CRTC_REG_COUNT  = 18;
  localparam int CRTC_MA_WIDTH   = 14;
  localparam int CRTC_RA_WIDTH   = 5;

  localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R0  = 5'd0;
  localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R1  = 5'd1;
  localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R2  = 5'd2;
  localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R3  = 5'd3;
  localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R4  = 5'd4;
  localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R5  = 5'd5;
  localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R6  = 5'd6;
  localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R7  = 5'd7;
  localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R8  = 5'd8;
  localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R9  = 5'd9;
  localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R10 = 5'd10;
  localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R11 = 5'd11;
  localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R12 = 5'd12;
  localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R13 = 5'd13;
  localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R14 = 5'd14;
  localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R15 = 5'd15;
  localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R16 = 5'd16;
  localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R17 = 5'd17;

  typedef enum logic {
    V_ROWS   = 1'b0,
    V_ADJUST = 1'b1
  } v_state_t;

  // Only the timing-relevant registers, each at its native CRTC width.
  typedef struct packed {
    logic [7:0] r0;   // horizontal total - 1
    logic [7:0] r1;   // horizontal displayed
    logic [7:0] r2;   // hsync position
    logic [7:0] r3;   // {vsync width, hsync width}
    logic [6:0] r4;   // vertical total - 1 (rows)
    logic [4:0] r5;   // vertical adjust (scan lines)
    logic [6:0] r6;   // vertical displayed
    logic [6:0] r7;   // vsync position
    logic [4:0] r9;   // max scan line
    logic [5:0] r12;  // start address high
    logic [7:0] r13;  // start address low
  } crtc_regs_t;

  // A vsync width nibble of zero encodes the maximum of 16 lines.
  function automatic logic [4:0] vsync_lines(input logic [3:0] nibble);
    return (nibble == 4'd0) ? 5'd16 : {1'b0, nibble};
  endfunction

endpackage

// File: rtl/crtc_reg_file.sv
// CRTC programming registers; writes to unimplemented indices are dropped and
// upper bits beyond each register's width are discarded.
module crtc_reg_file
  import common_pkg::*;
(
  input  logic                       clock_i,
  input  logic                       reset_ni,
  input  logic                       crtc_we,
  input  logic [CRTC_ADDR_WIDTH-1:0] crtc_addr,
  input  logic [DATA_WIDTH-1:0]      crtc_data,
  output crtc_regs_t                 regs
);

  crtc_regs_t regs_reg;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      regs_reg <= '0;
    end else if (crtc_we) begin
      case (crtc_addr)
        CRTC_R0:  regs_reg.r0  <= crtc_data[7:0];
        CRTC_R1:  regs_reg.r1  <= crtc_data[7:0];
        CRTC_R2:  regs_reg.r2  <= crtc_data[7:0];
        CRTC_R3:  regs_reg.r3  <= crtc_data[7:0];
        CRTC_R4:  regs_reg.r4  <= crtc_data[6:0];
        CRTC_R5:  regs_reg.r5  <= crtc_data[4:0];
        CRTC_R6:  regs_reg.r6  <= crtc_data[6:0];
        CRTC_R7:  regs_reg.r7  <= crtc_data[6:0];
        CRTC_R9:  regs_reg.r9  <= crtc_data[4:0];
        CRTC_R12: regs_reg.r12 <= crtc_data[5:0];
        CRTC_R13: regs_reg.r13 <= crtc_data[7:0];
        default:  ;
      endcase
    end
  end

  assign regs = regs_reg;

endmodule

// File: rtl/crtc_timing.sv
// 6845-style CRTC timing core: horizontal/vertical counters, sync width
// counters, vertical row/adjust FSM and memory address generation.
module crtc_timing
  import common_pkg::*;
(
  input  logic                       clock_i,
  input  logic                       reset_ni,
  input  logic                       cclk_en_i,
  input  logic                       crtc_we_i,
  input  logic [CRTC_ADDR_WIDTH-1:0] crtc_addr_i,
  input  logic [DATA_WIDTH-1:0]      crtc_data_i,
  output logic                       h_sync_o,
  output logic                       v_sync_o,
  output logic                       de_o,
  output logic [CRTC_MA_WIDTH-1:0]   screen_addr_o,
  output logic [CRTC_RA_WIDTH-1:0]   row_addr_o
);

  crtc_regs_t regs;

  crtc_reg_file u_reg_file (
    .clock_i   (clock_i),
    .reset_ni  (reset_ni),
    .crtc_we   (crtc_we_i),
    .crtc_addr (crtc_addr_i),
    .crtc_data (crtc_data_i),
    .regs      (regs)
  );

  logic [7:0]               h_count_reg,  h_count_next;
  logic [CRTC_RA_WIDTH-1:0] row_addr_reg, row_addr_next;
  logic [6:0]               v_count_reg,  v_count_next;
  v_state_t                 v_state_reg,  v_state_next;
  logic [CRTC_MA_WIDTH-1:0] row_base_reg, row_base_next;
  logic [3:0]               hs_cnt_reg,   hs_cnt_next;
  logic [4:0]               vs_cnt_reg,   vs_cnt_next;

  logic line_end;
  logic row_end;
  logic frame_end;
  logic hsync_hit;
  logic vsync_hit;
  logic adjust_last;

  assign line_end    = (h_count_reg == regs.r0);
  assign hsync_hit   = (h_count_reg == regs.r2) && (regs.r3[3:0] != 4'd0);
  assign vsync_hit   = (v_state_reg == V_ROWS) && (v_count_reg == regs.r7) &&
                       (row_addr_reg == '0);
  assign adjust_last = ((row_addr_reg + 5'd1) == regs.r5);

  always_comb begin
    row_end   = 1'b0;
    frame_end = 1'b0;
    case (v_state_reg)
      V_ROWS: begin
        if (line_end && (row_addr_reg == regs.r9)) begin
          row_end   = 1'b1;
          frame_end = (v_count_reg == regs.r4) && (regs.r5 == 5'd0);
        end
      end
      V_ADJUST: frame_end = line_end && adjust_last;
      default: ;
    endcase
  end

  always_comb begin
    h_count_next  = h_count_reg;
    row_addr_next = row_addr_reg;
    v_count_next  = v_count_reg;
    v_state_next  = v_state_reg;
    row_base_next = row_base_reg;
    hs_cnt_next   = hs_cnt_reg;
    vs_cnt_next   = vs_cnt_reg;

    if (cclk_en_i) begin
      h_count_next = line_end ? 8'd0 : h_count_reg + 8'd1;

      // The first hsync character comes from the compare itself; the counter
      // holds the remaining characters so the pulse survives a line wrap.
      if (hsync_hit) begin
        hs_cnt_next = regs.r3[3:0] - 4'd1;
      end else if (hs_cnt_reg != 4'd0) begin
        hs_cnt_next = hs_cnt_reg - 4'd1;
      end

      if (line_end) begin
        if (vsync_hit) begin
          vs_cnt_next = vsync_lines(regs.r3[7:4]) - 5'd1;
        end else if (vs_cnt_reg != 5'd0) begin
          vs_cnt_next = vs_cnt_reg - 5'd1;
        end
      end

      if (frame_end) begin
        v_count_next  = 7'd0;
        row_addr_next = '0;
        v_state_next  = V_ROWS;
        row_base_next = {regs.r12, regs.r13};
      end else if (row_end) begin
        row_addr_next = '0;
        row_base_next = row_base_reg + CRTC_MA_WIDTH'(regs.r1);
        if (v_count_reg == regs.r4) begin
          v_state_next = V_ADJUST;
        end else begin
          v_count_next = v_count_reg + 7'd1;
        end
      end else if (line_end) begin
        row_addr_next = row_addr_reg + 5'd1;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      h_count_reg  <= 8'd0;
      row_addr_reg <= '0;
      v_count_reg  <= 7'd0;
      v_state_reg  <= V_ROWS;
      row_base_reg <= '0;
      hs_cnt_reg   <= 4'd0;
      vs_cnt_reg   <= 5'd0;
    end else begin
      h_count_reg  <= h_count_next;
      row_addr_reg <= row_addr_next;
      v_count_reg  <= v_count_next;
      v_state_reg  <= v_state_next;
      row_base_reg <= row_base_next;
      hs_cnt_reg   <= hs_cnt_next;
      vs_cnt_reg   <= vs_cnt_next;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      h_sync_o      <= 1'b0;
      v_sync_o      <= 1'b0;
      de_o          <= 1'b0;
      screen_addr_o <= '0;
      row_addr_o    <= '0;
    end else begin
      h_sync_o      <= hsync_hit || (hs_cnt_reg != 4'd0);
      v_sync_o      <= vsync_hit || (vs_cnt_reg != 5'd0);
      de_o          <= (h_count_reg < regs.r1) && (v_state_reg == V_ROWS) &&
                       (v_count_reg < regs.r6);
      screen_addr_o <= row_base_reg + CRTC_MA_WIDTH'(h_count_reg);
      row_addr_o    <= row_addr_reg;
    end
  end

endmodule

// File: tb/tb_crtc_timing.sv
// Directed bench for crtc_timing: a frame-position model pushes expected
// outputs per character time, and each sample is popped and compared.
module tb_crtc_timing;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cclk_en;
  logic        we;
  logic [4:0]  addr;
  logic [7:0]  wdata;
  logic        hs, vs, de;
  logic [13:0] ma;
  logic [4:0]  ra;

  crtc_timing dut (
    .clock_i       (clk),
    .reset_ni      (rst_n),
    .cclk_en_i     (cclk_en),
    .crtc_we_i     (we),
    .crtc_addr_i   (addr),
    .crtc_data_i   (wdata),
    .h_sync_o      (hs),
    .v_sync_o      (vs),
    .de_o          (de),
    .screen_addr_o (ma),
    .row_addr_o    (ra)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [13:0] ma;
    logic [4:0]  ra;
  } obs_t;

  typedef struct {
    int r0, r1, r2, r3, r4, r5, r6, r7, r9, r12, r13;
  } cfg_t;

  obs_t  exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    step = 0;
  string phase = "init";
  cfg_t  cfg_zero, cfg_a, cfg_b, cfg_c, cfg_d;

  function automatic obs_t mk(input bit h, input bit v, input bit d,
                              input int m, input int r);
    obs_t o;
    o.hs = h;
    o.vs = v;
    o.de = d;
    o.ma = 14'(m);
    o.ra = 5'(r);
    return o;
  endfunction

  // Expected outputs for character idx counted from a clean frame origin;
  // the first frame starts at address 0, later frames at {R12,R13}.
  function automatic obs_t model(input int idx, input cfg_t c);
    int ll, line, h, rows_lines, frame_lines, fr, fl, v, r, rb, hw, vw, vstart;
    bit adj, hv, vv, dv;
    ll          = c.r0 + 1;
    line        = idx / ll;
    h           = idx % ll;
    rows_lines  = (c.r4 + 1) * (c.r9 + 1);
    frame_lines = rows_lines + c.r5;
    fr          = line / frame_lines;
    fl          = line % frame_lines;
    adj         = (fl >= rows_lines);
    v           = adj ? c.r4 : fl / (c.r9 + 1);
    r           = adj ? fl - rows_lines : fl % (c.r9 + 1);
    dv          = !adj && (h < c.r1) && (v < c.r6);
    rb          = ((fr == 0) ? 0 : (c.r12 * 256 + c.r13)) +
                  (adj ? (c.r4 + 1) * c.r1 : v * c.r1);
    hw          = c.r3 % 16;
    vw          = (c.r3 / 16 == 0) ? 16 : c.r3 / 16;
    vstart      = c.r7 * (c.r9 + 1);
    hv = 1'b0;
    for (int k = 0; k < hw; k++)
      if (idx - k >= 0 && (idx - k) % ll == c.r2) hv = 1'b1;
    vv = 1'b0;
    for (int k = 0; k < vw; k++)
      if (line - k >= 0 && (line - k) % frame_lines == vstart) vv = 1'b1;
    return mk(hv, vv, dv, (rb + h) % 16384, r);
  endfunction

  task automatic check();
    obs_t e, o;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s[%0d] scoreboard empty", phase, step);
      return;
    end
    e = exp_q.pop_front();
    o = {hs, vs, de, ma, ra};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s[%0d] observed hs=%b vs=%b de=%b ma=%h ra=%0d, expected hs=%b vs=%b de=%b ma=%h ra=%0d",
             phase, step, o.hs, o.vs, o.de, o.ma, o.ra, e.hs, e.vs, e.de, e.ma, e.ra);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cclk_en = 1'b1;
    @(negedge clk);
    cclk_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    we    = 1'b1;
    addr  = 5'(a);
    wdata = 8'(d);
    @(negedge clk);
    we    = 1'b0;
    $display("wr R%0d <= %02h", a, d & 255);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Upper junk bits exercise width truncation; out-of-set indices must not alias.
  task automatic apply_cfg(input cfg_t c);
    wr(0, c.r0);
    wr(1, c.r1);
    wr(2, c.r2);
    wr(3, c.r3);
    wr(4, c.r4 | 'h80);
    wr(5, c.r5 | 'hE0);
    wr(6, c.r6 | 'h80);
    wr(7, c.r7 | 'h80);
    wr(9, c.r9 | 'hE0);
    wr(12, c.r12 | 'hC0);
    wr(13, c.r13);
    wr(8, 'h55);
    wr(16, 'h00);
    wr(17, 'h01);
    wr(19, 'h00);
    wr(20, 'h55);
  endtask

  task automatic run(input cfg_t c, input int n, input string tag);
    phase = tag;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      step = i;
      exp_q.push_back(model(i, c));
      if (i > 0) tick();
      check();
    end
    $display("%s: %0d character times compared", tag, n);
  endtask

  initial begin
    rst_n   = 1'b0;
    cclk_en = 1'b0;
    we      = 1'b0;
    addr    = '0;
    wdata   = '0;

    cfg_zero = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    cfg_a    = '{9, 6, 7, 'h22, 3, 0, 2, 3, 1, 0, 'h10};
    cfg_b    = cfg_a;
    cfg_b.r5 = 2;
    cfg_c    = cfg_a;
    cfg_c.r3 = 0;
    cfg_c.r4 = 15;
    cfg_d    = cfg_a;
    cfg_d.r12 = 'h3F;
    cfg_d.r13 = 'hFE;

    // Power-on reset: outputs held at zero.
    repeat (3) @(negedge clk);
    phase = "por";
    step  = 0;
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    check();
    rst_n = 1'b1;

    // Basic timing and addressing over two frames.
    do_reset();
    apply_cfg(cfg_a);
    run(cfg_a, 175, "basic");

    // Mid-line reset: immediate clear, then restart from the origin.
    do_reset();
    apply_cfg(cfg_a);
    run(cfg_a, 36, "pre_reset");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    phase = "reset_async";
    step  = 0;
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    check();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(cfg_zero, 2, "post_reset");

    // Vertical adjust lines.
    do_reset();
    apply_cfg(cfg_b);
    run(cfg_b, 210, "adjust");

    // Zero sync widths: no hsync, 16-line vsync.
    do_reset();
    apply_cfg(cfg_c);
    run(cfg_c, 330, "widths");

    // Start address near the top of the 14-bit space.
    do_reset();
    apply_cfg(cfg_d);
    run(cfg_d, 100, "ma_wrap");

    // R0 rewritten on the very character edge where h_count==R0.
    do_reset();
    apply_cfg(cfg_a);
    run(cfg_a, 10, "pre_collision");
    phase = "collision";
    step  = 0;
    exp_q.push_back(mk(0, 0, 1, 0, 1));
    @(negedge clk);
    cclk_en = 1'b1;
    we      = 1'b1;
    addr    = 5'd0;
    wdata   = 8'd4;
    @(negedge clk);
    cclk_en = 1'b0;
    we      = 1'b0;
    @(negedge clk);
    check();
    for (int h = 1; h <= 4; h++) begin
      step = h;
      exp_q.push_back(mk(0, 0, 1, h, 1));
      tick();
      check();
    end
    for (int h = 0; h <= 4; h++) begin
      step = 5 + h;
      exp_q.push_back(mk(0, 0, 1, 6 + h, 0));
      tick();
      check();
    end
    step = 10;
    exp_q.push_back(mk(0, 0, 1, 6, 1));
    tick();
    check();
    $display("collision: directed sequence compared");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
